// File: rtl/atri_serial_pkg.sv
// Shared definitions for the ATRI daughterboard serial link.
// Used by the receiver and the future transmitter.
package atri_serial_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_START     = ST_START,
    S_DATA      = ST_DATA,
    S_STOP      = ST_STOP,
    S_WAIT_HIGH = ST_WAIT_HIGH
  } rx_state_e;

  function automatic int cnt_width(input int clks_per_bit);
    return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/atri_serial_if.sv
// Byte valid/ready handshake carried from the serial receiver
// to the daughterboard control logic.
interface atri_serial_if;

  logic [7:0] dat;
  logic       valid;
  logic       ready;

  modport master (
    output dat,
    output valid,
    input  ready
  );

  modport slave (
    input  dat,
    input  valid,
    output ready
  );

endinterface

// File: rtl/atri_sync2.sv
// Two-flop synchronizer with a configurable reset value.
// Reused wherever an asynchronous level enters the clk domain.
module atri_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/atri_serial_rx.sv
// 8N1 receiver for the daughterboard status link: mid-bit
// sampling FSM feeding a one-entry valid/ready output register.
import atri_serial_pkg::*;

module atri_serial_rx #(
  parameter int CLKS_PER_BIT = 416
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rx_i,
  output logic [7:0] dat_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  input  logic       clr_i,
  output logic       busy_o
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BIT - 1);

  logic          rxs;
  logic          rxs_q;
  logic          fall;
  rx_state_e     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;

  atri_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .d     (rx_i),
    .q     (rxs)
  );

  // Falling edge is registered so the FSM starts timing
  // the start bit on a clean, single-cycle event.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rxs_q <= 1'b1;
      fall  <= 1'b0;
    end else begin
      rxs_q <= rxs;
      fall  <= rxs_q & ~rxs;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      dat_o       <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      if (clr_i) begin
        overrun_o <= 1'b0;
      end
      // Later assignments below win: a delivery overrides
      // the pop and an overrun overrides the clear.
      unique case (state)
        S_IDLE: begin
          if (fall) begin
            state   <= S_START;
            cnt     <= HALF_LD;
            bit_cnt <= '0;
            busy_o  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt == '0) begin
            if (!rxs) begin
              state <= S_DATA;
              cnt   <= FULL_LD;
            end else begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == '0) begin
            shift   <= {rxs, shift[7:1]};
            cnt     <= FULL_LD;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              state <= S_STOP;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == '0) begin
            if (rxs) begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
              if (!valid_o || ready_i) begin
                dat_o   <= shift;
                valid_o <= 1'b1;
              end else begin
                overrun_o <= 1'b1;
              end
            end else begin
              frame_err_o <= 1'b1;
              state       <= S_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (rxs) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atri_serial_rx.sv
// Scoreboard bench for atri_serial_rx at CLKS_PER_BIT=8.
// Expected bytes and delivery cycles are queued as frames are sent.
module tb_atri_serial_rx;

  localparam int N   = 8;
  localparam int LAT = 3 + N / 2 + 9 * N;

  typedef struct {
    logic [7:0] dat;
    int         rise;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  logic clr   = 1'b0;
  logic fe;
  logic ovr;
  logic busy;

  atri_serial_if bus ();

  atri_serial_rx #(
    .CLKS_PER_BIT (N)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .rx_i        (rx),
    .dat_o       (bus.dat),
    .valid_o     (bus.valid),
    .ready_i     (bus.ready),
    .frame_err_o (fe),
    .overrun_o   (ovr),
    .clr_i       (clr),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   fe_cnt = 0;
  int   fe_cyc = -1;
  logic vprev  = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // First sampling edge of the start bit is cyc+1.
  task automatic send(input logic [7:0] b, input bit stop_ok,
                      input bit deliver, input bit clr_at_end);
    int k;
    k = cyc;
    if (deliver) q.push_back('{dat: b, rise: k + 1 + LAT});
    rx = 1'b0;
    tick(N);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(N);
    end
    rx = stop_ok;
    if (clr_at_end) begin
      tick(N - 1);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
    end else begin
      tick(N);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.valid && !vprev && q.size() != 0 && q[0].rise >= 0)
        chk("valid_rise_cycle", cyc, q[0].rise);
      if (bus.valid && bus.ready) begin
        if (q.size() == 0) begin
          chk("unexpected_byte", {24'd0, bus.dat}, 32'hffff_ffff);
        end else begin
          e = q.pop_front();
          chk("dat", {24'd0, bus.dat}, {24'd0, e.dat});
        end
      end
      if (fe) begin
        fe_cnt++;
        fe_cyc = cyc;
      end
    end
    vprev = bus.valid;
  end

  initial begin
    int k;
    logic [7:0] b;
    bus.ready = 1'b1;
    tick(3);
    chk("rst_dat", {24'd0, bus.dat}, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_fe", fe, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(3);

    send(8'hA5, 1'b1, 1'b1, 1'b0);
    tick(2);
    chk("a5_drained", q.size(), 0);
    chk("a5_fe", fe_cnt, 0);
    chk("a5_ovr", ovr, 0);

    send(8'h00, 1'b1, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b1, 1'b0);
    tick(2);
    chk("b2b_drained", q.size(), 0);

    k = cyc;
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(1);
    chk("glitch_busy_k3", busy, 0);
    tick(1);
    chk("glitch_busy_k4", busy, 1);
    tick(3);
    chk("glitch_busy_k7", busy, 1);
    tick(1);
    chk("glitch_busy_k8", busy, 0);
    tick(80);
    chk("glitch_valid", bus.valid, 0);
    chk("glitch_fe", fe_cnt, 0);

    k = cyc;
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk("ferr_count", fe_cnt, 1);
    chk("ferr_cycle", fe_cyc, k + 1 + LAT);
    chk("ferr_busy", busy, 1);
    tick(40);
    rx = 1'b1;
    tick(N);
    chk("ferr_idle", busy, 0);
    send(8'h11, 1'b1, 1'b1, 1'b0);
    tick(2);
    chk("ferr_11_drained", q.size(), 0);
    chk("ferr_count_end", fe_cnt, 1);

    bus.ready = 1'b0;
    send(8'h12, 1'b1, 1'b1, 1'b0);
    send(8'h34, 1'b1, 1'b0, 1'b0);
    tick(1);
    chk("ovr_hold_dat", {24'd0, bus.dat}, 32'h12);
    chk("ovr_hold_valid", bus.valid, 1);
    chk("ovr_set", ovr, 1);
    send(8'h56, 1'b1, 1'b0, 1'b1);
    chk("ovr_set_beats_clr", ovr, 1);
    chk("ovr_still_12", {24'd0, bus.dat}, 32'h12);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("ovr_cleared", ovr, 0);
    bus.ready = 1'b1;
    tick(2);
    chk("pop_valid", bus.valid, 0);
    chk("pop_drained", q.size(), 0);

    bus.ready = 1'b0;
    send(8'h77, 1'b1, 1'b0, 1'b0);
    tick(1);
    chk("held_77", {24'd0, bus.dat}, 32'h77);
    b = 8'h5A;
    rx = 1'b0;
    tick(N);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      tick(N);
    end
    rx = b[4];
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dat", {24'd0, bus.dat}, 0);
    chk("mid_rst_valid", bus.valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fe", fe, 0);
    chk("mid_rst_ovr", ovr, 0);
    tick(2);
    rx = 1'b1;
    tick(2);
    rst_n = 1'b1;
    bus.ready = 1'b1;
    tick(N);
    send(8'h5A, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
    chk("final_drained", q.size(), 0);
    chk("final_fe", fe_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/atri_serial_rx.md
# atri_serial_rx

Asynchronous 8N1 serial receiver for the ATRI daughterboard status link: the receiving end of the single-wire byte stream each daughterboard microcontroller transmits toward the FPGA. It synchronizes the raw line, recovers bytes by mid-bit sampling, and presents them on a one-entry valid/ready output register to the daughterboard control logic. Framing errors and overruns are flagged for the housekeeping registers.

## Interface
Parameters:
- CLKS_PER_BIT, 416, clock cycles per bit (48 MHz / 115200); legal range 8..65535; must be even.

Ports:
- clk_i  in  1  system clock; sole clock of the block.
- rst_n_i  in  1  reset; asynchronous, active-low.
- rx_i  in  1  raw serial line, asynchronous to clk_i, idle high.
- dat_o  out  8  received byte; valid while valid_o=1.
- valid_o  out  1  byte available.
- ready_i  in  1  consumer accepts byte when valid_o & ready_i.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- overrun_o  out  1  sticky: a byte was dropped because the output register was full.
- clr_i  in  1  clears overrun_o.
- busy_o  out  1  high in any state other than IDLE.

## Operation
- rx_i passes through a 2-flop synchronizer (both flops reset to 1), then one further edge-detect flop; all decisions use the synchronized value rxs.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: on rxs falling edge (prev=1, now=0) -> START, bit counter cleared.
- START: count CLKS_PER_BIT/2 cycles; at the end sample rxs. Low -> DATA. High -> IDLE (glitch, no flag).
- DATA: every CLKS_PER_BIT cycles sample rxs into a shift register, LSB first; after the 8th sample -> STOP.
- STOP: after CLKS_PER_BIT cycles sample rxs. High -> deliver byte, -> IDLE. Low -> pulse frame_err_o, discard byte, -> WAIT_HIGH.
- WAIT_HIGH: remain until rxs=1, then IDLE (no new frame is detected during a break).
- Delivery: if valid_o=0 or ready_i=1 in the delivery cycle, load dat_o and set valid_o. Otherwise keep the old byte, drop the new one, and set overrun_o.
- Pop: valid_o & ready_i with no delivery clears valid_o. Simultaneous pop and delivery loads the new byte and valid_o stays 1.
- overrun_o: set has priority over clr_i in the same cycle.
- Bit-period counter width is $clog2(CLKS_PER_BIT). It reloads at each sample point and never wraps mid-bit.

## Timing
- Reset values: dat_o=0x00, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0. FSM=IDLE; synchronizer flops and edge flop=1.
- Reset mid-frame discards the partial byte and any held output byte.
- Latency: valid_o rises exactly 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clock edges after the first clk_i edge that samples rx_i low. frame_err_o pulses on that same edge instead.
- busy_o rises 3 edges after that sampling edge and falls on the delivery edge.
- dat_o and valid_o are registered with no combinational path from ready_i. The consumer may hold ready_i high permanently.
- Back-to-back frames (stop bit followed immediately by a start bit) are received without loss: IDLE detects the falling edge on the next cycle.

## Structure
- Shared package (atri_serial_pkg): FSM state encoding localparams, and a function computing the counter width from CLKS_PER_BIT. A future atri_serial_tx uses the same package.
- One sub-module: atri_sync2, the reusable 2-flop synchronizer with parameterized reset value. Everything else is in a single module.

## Test plan
All scenarios use CLKS_PER_BIT=8, so the latency is 79 cycles.
- Single frame 0xA5, ready_i=1 -> valid_o one cycle at edge 79 with dat_o=0xA5; frame_err_o and overrun_o stay 0.
- Two back-to-back frames 0x00 then 0xFF, ready_i=1 -> two valid_o pulses, 80 cycles apart (10 bit-times), with dat_o 0x00 then 0xFF.
- Start glitch: rx_i low for 2 cycles, then high -> returns to IDLE, busy_o drops, no valid_o, no frame_err_o.
- Stop bit forced low on 0x3C, line held low for 40 cycles, then frame 0x11 -> one frame_err_o pulse, no 0x3C delivered, then 0x11 delivered.
- ready_i=0, frames 0x12 then 0x34 -> dat_o holds 0x12 and overrun_o=1. Raising ready_i pops 0x12. clr_i clears overrun_o, except in a cycle where a concurrent overrun occurs, where overrun_o stays 1.
- rst_n_i asserted at bit 4 of a frame -> all outputs at reset values immediately. After release with rx_i high, the next full frame 0x5A is received correctly.
